// File: rtl/store_write_buffer.sv
// Store write buffer between the CPU store path and data memory.
// Stores are queued in a small FIFO of {word address, data} entries and
// drained to memory one per cycle while drain_en is high. Loads probe every
// occupied entry combinationally; the youngest matching entry decides.
//
// Build option: STORE_FWD_EN
//   defined   -> a matching load is served from the buffer (ld_hit/ld_data)
//   undefined -> a matching load raises ld_conflict and the CPU must stall
//                until the matching store has drained

module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic                       ld_hit,
    output logic [31:0]                ld_data,
    output logic                       ld_conflict,
    input  logic                       drain_en,
    output logic                       mem_write,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; contents are only meaningful for occupied slots, so it
    // carries no reset.
    logic [29:0] entryAddr [DEPTH];
    logic [31:0] entryData [DEPTH];

    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] occupancy;

    logic doPush;
    logic doPop;
    logic matchFound;
    logic [31:0] matchData;

    // Byte-offset bits of both addresses are deliberately ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = &{1'b0, st_addr[1:0], ld_addr[1:0]};

    assign count     = occupancy;
    assign empty     = (occupancy == '0);
    assign st_ready  = (occupancy != CNT_W'(DEPTH));
    assign doPush    = st_valid && st_ready;
    assign mem_write = drain_en && !empty;
    assign doPop     = mem_write;

    // The head entry drives memory directly; outputs are zeroed when empty.
    assign mem_addr  = empty ? 32'h0 : {entryAddr[headPtr], 2'b00};
    assign mem_wdata = empty ? 32'h0 : entryData[headPtr];

    // Pointer and occupancy update; reset discards any pending stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
        end else begin
            if (doPush) begin
                tailPtr <= tailPtr + 1'b1;
            end
            if (doPop) begin
                headPtr <= headPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Write the accepted store into the tail slot.
    always_ff @(posedge clk) begin
        if (doPush) begin
            entryAddr[tailPtr] <= st_addr[31:2];
            entryData[tailPtr] <= st_data;
        end
    end

    // Load probe: walk occupied slots oldest to youngest so the last match
    // (youngest) wins. A store being pushed this cycle is not yet occupied,
    // and the draining head still counts as occupied.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        matchFound = 1'b0;
        matchData  = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = headPtr + PTR_W'(i);
            if (ld_valid && (CNT_W'(i) < occupancy) &&
                (entryAddr[idx] == ld_addr[31:2])) begin
                matchFound = 1'b1;
                matchData  = entryData[idx];
            end
        end
    end

`ifdef STORE_FWD_EN
    assign ld_hit      = matchFound;
    assign ld_data     = matchFound ? matchData : 32'h0;
    assign ld_conflict = 1'b0;
`else
    logic unusedMatchData;
    assign unusedMatchData = &{1'b0, matchData};
    assign ld_hit      = 1'b0;
    assign ld_data     = 32'h0;
    assign ld_conflict = matchFound;
`endif

endmodule
